// File: rtl/dft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : dft_frame_ctrl                                               |
// | Description : Frame sequencer for the DFT pipeline. Arms on start, waits   |
// |               for a trigger, forwards one frame of ADC samples with a      |
// |               single frame_start strobe, and writes the DFT results into   |
// |               the result RAM. Flags input overrun and, when the macro      |
// |               DFT_FRAME_CTRL_TIMEOUT_EN is defined, a stalled DFT output.  |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module dft_frame_ctrl #(
    parameter int DATA_W      = 12,
    parameter int OUT_W       = 15,
    parameter int IN_SAMPLES  = 8192,
    parameter int OUT_SAMPLES = 256,
    parameter int TIMEOUT_CYC = 65535
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           abort,
    input  logic                           trig,
    input  logic signed [DATA_W-1:0]       adc_data,
    input  logic                           adc_valid,
    output logic [DATA_W-1:0]              dft_data_in,
    output logic                           dft_valid_in,
    output logic                           dft_frame_start,
    input  logic                           dft_ready,
    input  logic [OUT_W-1:0]               dft_data_out,
    input  logic                           dft_valid_out,
    output logic [$clog2(OUT_SAMPLES)-1:0] res_addr,
    output logic [OUT_W-1:0]               res_data,
    output logic                           res_we,
    output logic                           busy,
    output logic                           done,
    output logic                           overflow,
    output logic                           timeout
);

    localparam int c_IN_CNT_W  = $clog2(IN_SAMPLES) + 1;
    localparam int c_OUT_CNT_W = $clog2(OUT_SAMPLES) + 1;
    localparam int c_ADDR_W    = $clog2(OUT_SAMPLES);

    localparam logic [c_IN_CNT_W-1:0]  c_IN_LAST  = c_IN_CNT_W'(IN_SAMPLES - 1);
    localparam logic [c_OUT_CNT_W-1:0] c_OUT_N    = c_OUT_CNT_W'(OUT_SAMPLES);
    localparam logic [c_OUT_CNT_W-1:0] c_OUT_LAST = c_OUT_CNT_W'(OUT_SAMPLES - 1);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ARMED = 2'd1;
    localparam logic [1:0] c_ACQ   = 2'd2;
    localparam logic [1:0] c_DRAIN = 2'd3;

    // A frame needs at least two samples and the watchdog limit must be non-zero
    if (IN_SAMPLES < 2 || TIMEOUT_CYC < 1) begin : g_param_check
        $error("dft_frame_ctrl: IN_SAMPLES must be >= 2 and TIMEOUT_CYC >= 1");
    end

    logic [1:0]             r_state;
    logic [c_IN_CNT_W-1:0]  r_in_cnt;
    logic [c_OUT_CNT_W-1:0] r_out_cnt;
    logic                   r_trig_seen;

    logic w_sample_go;
    logic w_out_ok;

    // First sample of a frame needs a trigger now or one remembered from earlier
    assign w_sample_go = adc_valid && (trig || r_trig_seen);
    // Results past the expected count are dropped
    assign w_out_ok    = dft_valid_out && (r_out_cnt < c_OUT_N);

`ifdef DFT_FRAME_CTRL_TIMEOUT_EN
    localparam int                c_WD_W    = $clog2(TIMEOUT_CYC + 1);
    localparam logic [c_WD_W-1:0] c_WD_LAST = c_WD_W'(TIMEOUT_CYC - 1);

    logic [c_WD_W-1:0] r_wd_cnt;

    // Watchdog: cycles spent in DRAIN since entry or since the last DFT output
    always_ff @(posedge clk) begin
        if (!rst || r_state != c_DRAIN || dft_valid_out) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_LAST) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Frame sequencer with registered forwarding, result-write and status outputs
    always_ff @(posedge clk) begin
        dft_valid_in    <= 1'b0;
        dft_frame_start <= 1'b0;
        res_we          <= 1'b0;
        done            <= 1'b0;
        if (!rst) begin
            r_state     <= c_IDLE;
            r_in_cnt    <= '0;
            r_out_cnt   <= '0;
            r_trig_seen <= 1'b0;
            dft_data_in <= '0;
            res_addr    <= '0;
            res_data    <= '0;
            busy        <= 1'b0;
            overflow    <= 1'b0;
`ifdef DFT_FRAME_CTRL_TIMEOUT_EN
            timeout     <= 1'b0;
`endif
        end else if (abort) begin
            // Abort beats every other event and leaves the sticky flags alone
            r_state     <= c_IDLE;
            r_trig_seen <= 1'b0;
            busy        <= 1'b0;
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (start) begin
                        r_state     <= c_ARMED;
                        r_in_cnt    <= '0;
                        r_out_cnt   <= '0;
                        r_trig_seen <= 1'b0;
                        overflow    <= 1'b0;
`ifdef DFT_FRAME_CTRL_TIMEOUT_EN
                        timeout     <= 1'b0;
`endif
                        busy        <= 1'b1;
                    end
                end
                c_ARMED: begin
                    if (w_sample_go) begin
                        if (!dft_ready) begin
                            overflow <= 1'b1;
                            r_state  <= c_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            dft_data_in     <= adc_data;
                            dft_valid_in    <= 1'b1;
                            dft_frame_start <= 1'b1;
                            r_in_cnt        <= c_IN_CNT_W'(1);
                            r_state         <= c_ACQ;
                        end
                    end else if (trig) begin
                        r_trig_seen <= 1'b1;
                    end
                end
                c_ACQ: begin
                    if (w_out_ok) begin
                        res_we    <= 1'b1;
                        res_addr  <= r_out_cnt[c_ADDR_W-1:0];
                        res_data  <= dft_data_out;
                        r_out_cnt <= r_out_cnt + 1'b1;
                    end
                    if (adc_valid) begin
                        if (!dft_ready) begin
                            overflow <= 1'b1;
                            r_state  <= c_IDLE;
                            busy     <= 1'b0;
                        end else begin
                            dft_data_in  <= adc_data;
                            dft_valid_in <= 1'b1;
                            r_in_cnt     <= r_in_cnt + 1'b1;
                            if (r_in_cnt == c_IN_LAST) begin
                                r_state <= c_DRAIN;
                            end
                        end
                    end
                end
                default: begin
                    // DRAIN: done pulses alongside the final write, state leaves one cycle later
                    if (done) begin
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
                    end else if (r_out_cnt == c_OUT_N) begin
                        done <= 1'b1;
                    end else if (w_out_ok) begin
                        res_we    <= 1'b1;
                        res_addr  <= r_out_cnt[c_ADDR_W-1:0];
                        res_data  <= dft_data_out;
                        r_out_cnt <= r_out_cnt + 1'b1;
                        if (r_out_cnt == c_OUT_LAST) begin
                            done <= 1'b1;
                        end
`ifdef DFT_FRAME_CTRL_TIMEOUT_EN
                    end else if (r_wd_cnt == c_WD_LAST) begin
                        timeout <= 1'b1;
                        r_state <= c_IDLE;
                        busy    <= 1'b0;
`endif
                    end
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dft_frame_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module      : tb_dft_frame_ctrl                                            |
// | Description : Self-checking bench for dft_frame_ctrl with a short frame    |
// |               (32 in, 2 out, watchdog limit 100). Honours the macro        |
// |               DFT_FRAME_CTRL_TIMEOUT_EN for the watchdog scenario.         |
// | Revision    : 1.0  initial release                                         |
// +----------------------------------------------------------------------------+
module tb_dft_frame_ctrl;

    localparam int DATA_W = 12;
    localparam int OUT_W  = 15;
    localparam int IN_N   = 32;
    localparam int OUT_N  = 2;
    localparam int TMO    = 100;

    logic              clk = 1'b0;
    logic              rst;
    logic              start, abort, trig, adc_valid, dft_ready, dft_valid_out;
    logic [DATA_W-1:0] adc_data;
    logic [OUT_W-1:0]  dft_data_out;
    logic [DATA_W-1:0] dft_data_in;
    logic              dft_valid_in, dft_frame_start;
    logic [0:0]        res_addr;
    logic [OUT_W-1:0]  res_data;
    logic              res_we, busy, done, overflow, timeout;

    int checks   = 0;
    int failures = 0;

    dft_frame_ctrl #(
        .DATA_W(DATA_W), .OUT_W(OUT_W), .IN_SAMPLES(IN_N),
        .OUT_SAMPLES(OUT_N), .TIMEOUT_CYC(TMO)
    ) u_dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .trig(trig),
        .adc_data(adc_data), .adc_valid(adc_valid),
        .dft_data_in(dft_data_in), .dft_valid_in(dft_valid_in),
        .dft_frame_start(dft_frame_start), .dft_ready(dft_ready),
        .dft_data_out(dft_data_out), .dft_valid_out(dft_valid_out),
        .res_addr(res_addr), .res_data(res_data), .res_we(res_we),
        .busy(busy), .done(done), .overflow(overflow), .timeout(timeout)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        start, abort, trig, av;
        logic [11:0] ad;
        logic        rdy, vo;
        logic [14:0] dout;
        logic        e_vin, e_fs;
        logic [11:0] e_din;
        logic        e_we, e_addr;
        logic [14:0] e_rdata;
        logic        e_busy, e_done, e_ovf;
    } vec_t;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        start = 1'b0; abort = 1'b0; trig = 1'b0; adc_valid = 1'b0; adc_data = '0;
        dft_ready = 1'b1; dft_valid_out = 1'b0; dft_data_out = '0;
    endtask

    function automatic logic [63:0] all_outs();
        return 64'({dft_valid_in, dft_frame_start, dft_data_in, res_we, res_addr,
                    res_data, busy, done, overflow, timeout});
    endfunction

    // start, then one full frame of triggered samples; optionally inject both DFT outputs during ACQ
    task automatic feed_frame(input bit out_in_acq);
        int n_vin, n_fs, n_we;
        bit data_ok;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("start_busy", 64'(busy), 64'd1);
        n_vin = 0; n_fs = 0; n_we = 0; data_ok = 1'b1;
        for (int k = 0; k < IN_N; k++) begin
            trig          = 1'b1;
            adc_valid     = 1'b1;
            adc_data      = 12'(k * 37 + 5);
            dft_valid_out = out_in_acq && (k == 5 || k == 6);
            dft_data_out  = 15'(k * 100);
            tick();
            if (dft_valid_in) begin
                n_vin++;
                if (dft_data_in !== 12'(k * 37 + 5)) data_ok = 1'b0;
            end
            if (dft_frame_start) begin
                n_fs++;
                if (k != 0) data_ok = 1'b0;
            end
            if (res_we) begin
                if (res_addr !== 1'(n_we) || res_data !== 15'(k * 100)) data_ok = 1'b0;
                n_we++;
            end
            if (done) data_ok = 1'b0;
        end
        trig = 1'b0; adc_valid = 1'b0; dft_valid_out = 1'b0;
        chk("frame_vin_count", 64'(n_vin), 64'(IN_N));
        chk("frame_start_count", 64'(n_fs), 64'd1);
        chk("frame_data", 64'(data_ok), 64'd1);
        chk("frame_acq_writes", 64'(n_we), out_in_acq ? 64'd2 : 64'd0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL global_time_limit: actual=expired required=finished");
        $fatal(1, "simulation time limit");
    end

    initial begin
        vec_t vecs[12];
        logic [33:0] v_exp, v_act;
        int n;

        vecs[0]  = '{1'b0,1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};
        vecs[1]  = '{1'b1,1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b1,1'b0,1'b0};
        vecs[2]  = '{1'b0,1'b0,1'b1,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b1,1'b0,1'b0};
        vecs[3]  = '{1'b0,1'b0,1'b0,1'b1,12'h123,1'b1,1'b0,15'h0000, 1'b1,1'b1,12'h123,1'b0,1'b0,15'h0000,1'b1,1'b0,1'b0};
        vecs[4]  = '{1'b0,1'b0,1'b0,1'b1,12'h456,1'b1,1'b0,15'h0000, 1'b1,1'b0,12'h456,1'b0,1'b0,15'h0000,1'b1,1'b0,1'b0};
        vecs[5]  = '{1'b0,1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,15'h1abc, 1'b0,1'b0,12'h000,1'b1,1'b0,15'h1abc,1'b1,1'b0,1'b0};
        vecs[6]  = '{1'b0,1'b1,1'b0,1'b1,12'h789,1'b1,1'b1,15'h0042, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};
        vecs[7]  = '{1'b0,1'b0,1'b0,1'b0,12'h000,1'b1,1'b1,15'h0005, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};
        vecs[8]  = '{1'b1,1'b1,1'b0,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};
        vecs[9]  = '{1'b0,1'b0,1'b1,1'b1,12'h055,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};
        vecs[10] = '{1'b1,1'b0,1'b0,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b1,1'b0,1'b0};
        vecs[11] = '{1'b0,1'b1,1'b0,1'b0,12'h000,1'b1,1'b0,15'h0000, 1'b0,1'b0,12'h000,1'b0,1'b0,15'h0000,1'b0,1'b0,1'b0};

        // Reset state
        idle_inputs();
        rst = 1'b0;
        repeat (3) tick();
        chk("reset_outputs", all_outs(), 64'd0);
        rst = 1'b1;

        // Table: trigger latch, first-sample strobe, ACQ write, abort priority, IDLE ignores
        for (int i = 0; i < 12; i++) begin
            start = vecs[i].start; abort = vecs[i].abort; trig = vecs[i].trig;
            adc_valid = vecs[i].av; adc_data = vecs[i].ad; dft_ready = vecs[i].rdy;
            dft_valid_out = vecs[i].vo; dft_data_out = vecs[i].dout;
            tick();
            v_exp = {vecs[i].e_vin, vecs[i].e_fs, vecs[i].e_vin ? vecs[i].e_din : 12'h000,
                     vecs[i].e_we, vecs[i].e_we ? vecs[i].e_addr : 1'b0,
                     vecs[i].e_we ? vecs[i].e_rdata : 15'h0000,
                     vecs[i].e_busy, vecs[i].e_done, vecs[i].e_ovf};
            v_act = {dft_valid_in, dft_frame_start, vecs[i].e_vin ? dft_data_in : 12'h000,
                     res_we, vecs[i].e_we ? res_addr : 1'b0,
                     vecs[i].e_we ? res_data : 15'h0000, busy, done, overflow};
            chk($sformatf("vec%0d", i), 64'(v_act), 64'(v_exp));
        end
        idle_inputs();
        tick();

        // Nominal frame, outputs delivered in DRAIN
        feed_frame(1'b0);
        adc_valid = 1'b1; adc_data = 12'hfff; dft_valid_out = 1'b1; dft_data_out = 15'h0111;
        tick();
        chk("drain_no_forward", 64'(dft_valid_in), 64'd0);
        chk("drain_w0", 64'({res_we, res_addr, res_data, done}), 64'({1'b1, 1'b0, 15'h0111, 1'b0}));
        adc_valid = 1'b0; dft_data_out = 15'h0222;
        tick();
        chk("drain_w1_done", 64'({res_we, res_addr, res_data, done, busy}),
            64'({1'b1, 1'b1, 15'h0222, 1'b1, 1'b1}));
        dft_data_out = 15'h0333;
        tick();
        chk("after_done", 64'({res_we, done, busy}), 64'd0);
        idle_inputs();
        tick();

        // Overrun on sample 10
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k <= 10; k++) begin
            trig = 1'b1; adc_valid = 1'b1; adc_data = 12'(k);
            dft_ready = (k != 10);
            tick();
        end
        chk("ovf_state", 64'({dft_valid_in, overflow, busy}), 64'({1'b0, 1'b1, 1'b0}));
        idle_inputs();
        tick();
        chk("ovf_no_done", 64'({done, overflow, busy}), 64'({1'b0, 1'b1, 1'b0}));
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("ovf_cleared", 64'({overflow, busy}), 64'({1'b0, 1'b1}));
        abort = 1'b1;
        tick();
        abort = 1'b0;

        // Abort in DRAIN after one of two outputs
        feed_frame(1'b0);
        dft_valid_out = 1'b1; dft_data_out = 15'h0007;
        tick();
        chk("abort_pre_write", 64'({res_we, res_addr}), 64'({1'b1, 1'b0}));
        dft_valid_out = 1'b0; abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_idle", 64'({busy, done, res_we}), 64'd0);
        dft_valid_out = 1'b1; dft_data_out = 15'h0008;
        tick();
        chk("abort_no_write", 64'({res_we, done}), 64'd0);
        idle_inputs();
        tick();

        // Watchdog with DFT outputs withheld
        feed_frame(1'b0);
`ifdef DFT_FRAME_CTRL_TIMEOUT_EN
        n = 0;
        while (!timeout && n < 3 * TMO) begin
            tick();
            n++;
        end
        chk("timeout_cycles", 64'(n), 64'(TMO));
        chk("timeout_state", 64'({timeout, busy, done}), 64'({1'b1, 1'b0, 1'b0}));
`else
        n = 0;
        repeat (1000) begin
            tick();
            if (!busy) n++;
        end
        chk("drain_waits", 64'({busy, timeout}), 64'({1'b1, 1'b0}));
        chk("drain_never_idle", 64'(n), 64'd0);
        abort = 1'b1;
        tick();
        abort = 1'b0;
`endif
        idle_inputs();
        tick();

        // Reset mid-ACQ, then a full frame with outputs completing during ACQ
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int k = 0; k < 5; k++) begin
            trig = 1'b1; adc_valid = 1'b1; adc_data = 12'(k + 1);
            tick();
        end
        rst = 1'b0;
        tick();
        rst = 1'b1;
        chk("midacq_reset", all_outs(), 64'd0);
        idle_inputs();
        tick();
        feed_frame(1'b1);
        tick();
        chk("acq_done_on_drain", 64'({done, busy, res_we}), 64'({1'b1, 1'b1, 1'b0}));
        tick();
        chk("acq_done_idle", 64'({done, busy}), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
